// File: rtl/ahb_capture_fifo.sv
// ahb_capture_fifo: AHB-Lite slave packing camera bytes into 32-bit words buffered in a block-RAM FIFO
module ahb_capture_fifo #(
    parameter int DEPTH_LOG2 = 9,
    parameter int THRESH_RST = 128
) (
    input  logic        FAB_CLK,
    input  logic        FAB_RESET,
    input  logic [7:0]  PIX_DATA,
    input  logic        PIX_VALID,
    input  logic        PIX_SOF,
    input  logic        HSEL,
    input  logic [3:0]  HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic        HREADYOUT,
    output logic        HRESP,
    output logic [31:0] HRDATA,
    output logic        FABINT
);
    localparam int DEPTH = 2 ** DEPTH_LOG2;
    logic [31:0] mem [DEPTH];
    logic [31:0] ram_q, pk, status, rdata;
    logic [DEPTH_LOG2-1:0] wptr, rptr;
    logic [DEPTH_LOG2:0] level;
    logic [15:0] level16, thresh;
    logic [1:0] phase, dp_reg, idx;
    logic enable, irq_en, overflow, push_pend;
    logic dp_valid, dp_write, d2, rd_empty;
    logic empty, full, acc, pop_d1, pop, wr, flush, push_ok, pending, pix_ok;
    logic unused;
    assign unused = ^{HADDR[1:0], HTRANS[0], HWDATA[31:19], HWDATA[17:16]};
    assign level16 = 16'(level);
    assign empty = level == '0;
    assign full = level[DEPTH_LOG2];
    assign acc = HSEL & HREADY & HTRANS[1];
    assign wr = dp_valid & dp_write;
    assign pop_d1 = dp_valid & ~dp_write & (dp_reg == 2'd0) & ~d2;
    assign flush = wr & (dp_reg == 2'd2) & HWDATA[2];
    assign pop = pop_d1 & ~empty & ~flush;
    assign push_ok = push_pend & ~full & ~flush;
    assign pix_ok = enable & PIX_VALID;
    assign idx = PIX_SOF ? 2'd0 : phase;
    assign pending = ((level16 >= thresh) && (thresh != 16'd0)) | overflow;
    assign status = {12'd0, pending, overflow, full, empty, level16};
    assign rdata = dp_reg == 2'd1 ? status :
                   dp_reg == 2'd2 ? {30'd0, irq_en, enable} :
                   dp_reg == 2'd3 ? {16'd0, thresh} :
                   (d2 && !rd_empty) ? ram_q : 32'd0;
    assign HRDATA = (dp_valid && !dp_write) ? rdata : 32'd0;
    assign HREADYOUT = ~pop_d1;
    assign HRESP = 1'b0;
    always_ff @(posedge FAB_CLK) begin
        if (push_ok) mem[wptr] <= pk;
        if (pop_d1) ram_q <= mem[rptr];
    end
    always_ff @(posedge FAB_CLK) begin
        if (FAB_RESET) begin
            dp_valid <= 1'b0;
            dp_write <= 1'b0;
            dp_reg <= 2'd0;
            d2 <= 1'b0;
            rd_empty <= 1'b1;
            enable <= 1'b0;
            irq_en <= 1'b0;
            thresh <= 16'(THRESH_RST);
            overflow <= 1'b0;
            phase <= 2'd0;
            pk <= 32'd0;
            push_pend <= 1'b0;
            wptr <= '0;
            rptr <= '0;
            level <= '0;
            FABINT <= 1'b0;
        end else begin
            if (HREADY) begin
                dp_valid <= acc;
                dp_write <= HWRITE;
                dp_reg <= HADDR[3:2];
            end
            d2 <= pop_d1;
            if (pop_d1) rd_empty <= empty;
            if (wr && dp_reg == 2'd2) begin
                enable <= HWDATA[0];
                irq_en <= HWDATA[1];
            end
            if (wr && dp_reg == 2'd3) thresh <= HWDATA[15:0];
            overflow <= (push_pend & full & ~flush) | (overflow & ~(wr & (dp_reg == 2'd1) & HWDATA[18]));
            push_pend <= ~flush & pix_ok & ~PIX_SOF & (phase == 2'd3);
            if (pix_ok) pk[{idx, 3'b000} +: 8] <= PIX_DATA;
            if (flush) phase <= 2'd0;
            else if (pix_ok) phase <= idx + 2'd1;
            if (flush) begin
                wptr <= '0;
                rptr <= '0;
                level <= '0;
            end else begin
                if (push_ok) wptr <= wptr + 1'b1;
                if (pop) rptr <= rptr + 1'b1;
                level <= level + (DEPTH_LOG2 + 1)'(push_ok) - (DEPTH_LOG2 + 1)'(pop);
            end
            FABINT <= irq_en & pending;
        end
    end
endmodule

// File: tb/tb_ahb_capture_fifo.sv
// tb_ahb_capture_fifo: scoreboard bench for the AHB capture FIFO
module tb_ahb_capture_fifo;
    logic        FAB_CLK = 1'b0;
    logic        FAB_RESET;
    logic [7:0]  PIX_DATA;
    logic        PIX_VALID;
    logic        PIX_SOF;
    logic        HSEL;
    logic [3:0]  HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic        HREADYOUT;
    logic        HRESP;
    logic [31:0] HRDATA;
    logic        FABINT;
    int pass_cnt = 0;
    int total_cnt = 0;
    logic [31:0] q[$];
    logic [31:0] pk_m;
    int ph_m = 0;
    bit en_m = 0;
    bit ovf_m = 0;
    int thresh_m = 128;

    ahb_capture_fifo dut (
        .FAB_CLK(FAB_CLK), .FAB_RESET(FAB_RESET), .PIX_DATA(PIX_DATA), .PIX_VALID(PIX_VALID),
        .PIX_SOF(PIX_SOF), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE),
        .HWDATA(HWDATA), .HREADY(HREADY), .HREADYOUT(HREADYOUT), .HRESP(HRESP),
        .HRDATA(HRDATA), .FABINT(FABINT)
    );

    always #5 FAB_CLK = ~FAB_CLK;
    assign HREADY = HREADYOUT;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic logic [31:0] exp_status();
        int lvl = q.size();
        logic pend = ((lvl >= thresh_m) && (thresh_m != 0)) || ovf_m;
        return {12'd0, pend, ovf_m, lvl == 512, lvl == 0, lvl[15:0]};
    endfunction

    task automatic ahb_write(input logic [3:0] a, input logic [31:0] d);
        @(posedge FAB_CLK); #1;
        HSEL = 1; HTRANS = 2'b10; HWRITE = 1; HADDR = a;
        @(posedge FAB_CLK); #1;
        HSEL = 0; HTRANS = 2'b00; HWRITE = 0; HWDATA = d;
    endtask

    task automatic ahb_read(input logic [3:0] a, output logic [31:0] d, output int w);
        @(posedge FAB_CLK); #1;
        HSEL = 1; HTRANS = 2'b10; HWRITE = 0; HADDR = a;
        @(posedge FAB_CLK); #1;
        HSEL = 0; HTRANS = 2'b00;
        w = 0;
        while (HREADYOUT !== 1'b1 && w < 8) begin
            @(posedge FAB_CLK); #1;
            w++;
        end
        d = HRDATA;
    endtask

    task automatic pop_exp(output logic [31:0] d, output int w, output logic [31:0] e);
        ahb_read(4'h0, d, w);
        e = (q.size() != 0) ? q.pop_front() : 32'd0;
    endtask

    task automatic pix(input logic [7:0] b, input logic sof);
        @(posedge FAB_CLK); #1;
        PIX_VALID = 1; PIX_DATA = b; PIX_SOF = sof;
        if (en_m) begin
            if (sof) ph_m = 0;
            pk_m[ph_m*8 +: 8] = b;
            ph_m++;
            if (ph_m == 4) begin
                ph_m = 0;
                if (q.size() == 512) ovf_m = 1;
                else q.push_back(pk_m);
            end
        end
    endtask

    task automatic idle();
        @(posedge FAB_CLK); #1;
        PIX_VALID = 0; PIX_SOF = 0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        int w;
        FAB_RESET = 1; PIX_DATA = 0; PIX_VALID = 0; PIX_SOF = 0;
        HSEL = 0; HADDR = 0; HTRANS = 0; HWRITE = 0; HWDATA = 0;
        repeat (3) @(posedge FAB_CLK);
        #1 FAB_RESET = 0;
        total_cnt++;
        if ({HREADYOUT, HRESP, FABINT, HRDATA} !== {3'b100, 32'd0})
            $display("FAIL reset_outputs got rdy=%b resp=%b int=%b rdata=%h exp 1 0 0 0", HREADYOUT, HRESP, FABINT, HRDATA);
        else pass_cnt++;
        ahb_read(4'h8, d, w);
        total_cnt++;
        if (d !== 32'h0 || w !== 0) $display("FAIL reset_ctrl got %h w=%0d exp 00000000 w=0", d, w);
        else pass_cnt++;
        ahb_read(4'h4, d, w);
        total_cnt++;
        if (d !== 32'h0001_0000) $display("FAIL reset_status got %h exp 00010000", d);
        else pass_cnt++;
        ahb_read(4'hC, d, w);
        total_cnt++;
        if (d !== 32'h0000_0080) $display("FAIL reset_thresh got %h exp 00000080", d);
        else pass_cnt++;
    endtask

    task automatic test_pack();
        logic [31:0] d, e;
        int w;
        ahb_write(4'h8, 32'h1);
        en_m = 1;
        for (int i = 1; i <= 8; i++) pix(8'(i), 1'b0);
        idle();
        ahb_read(4'h4, d, w);
        total_cnt++;
        if (d !== exp_status() || d[15:0] !== 16'd2) $display("FAIL pack_level got %h exp %h", d, exp_status());
        else pass_cnt++;
        for (int k = 0; k < 2; k++) begin
            pop_exp(d, w, e);
            total_cnt++;
            if (d !== e || w !== 1) $display("FAIL pack_pop%0d got %h w=%0d exp %h w=1", k, d, w, e);
            else pass_cnt++;
        end
        ahb_read(4'h4, d, w);
        total_cnt++;
        if (d !== 32'h0001_0000) $display("FAIL pack_status_empty got %h exp 00010000", d);
        else pass_cnt++;
    endtask

    task automatic test_full_overflow();
        logic [31:0] d;
        int w;
        for (int i = 0; i < 2048; i++) pix(8'(i * 7), 1'b0);
        idle();
        ahb_read(4'h4, d, w);
        total_cnt++;
        if (d !== exp_status() || d[17] !== 1'b1 || d[15:0] !== 16'd512) $display("FAIL full_status got %h exp %h", d, exp_status());
        else pass_cnt++;
        for (int i = 0; i < 4; i++) pix(8'hE0 + 8'(i), 1'b0);
        idle();
        ahb_read(4'h4, d, w);
        total_cnt++;
        if (d !== exp_status() || d[18] !== 1'b1 || d[15:0] !== 16'd512) $display("FAIL overflow_status got %h exp %h", d, exp_status());
        else pass_cnt++;
        ahb_write(4'h4, 32'h0004_0000);
        ovf_m = 0;
        ahb_read(4'h4, d, w);
        total_cnt++;
        if (d !== exp_status() || d[18] !== 1'b0) $display("FAIL overflow_clear got %h exp %h", d, exp_status());
        else pass_cnt++;
    endtask

    task automatic test_irq();
        logic [31:0] d, e;
        int w;
        ahb_write(4'h8, 32'h4);
        q.delete(); ph_m = 0; en_m = 0;
        ahb_write(4'hC, 32'h4);
        thresh_m = 4;
        ahb_write(4'h8, 32'h3);
        en_m = 1;
        for (int i = 0; i < 16; i++) pix(8'h10 + 8'(i), 1'b0);
        idle();
        total_cnt++;
        if (FABINT !== 1'b0) $display("FAIL irq_level3 got %b exp 0", FABINT);
        else pass_cnt++;
        @(posedge FAB_CLK); #1;
        total_cnt++;
        if (FABINT !== 1'b0) $display("FAIL irq_same_cycle got %b exp 0", FABINT);
        else pass_cnt++;
        @(posedge FAB_CLK); #1;
        total_cnt++;
        if (FABINT !== 1'b1) $display("FAIL irq_rise got %b exp 1", FABINT);
        else pass_cnt++;
        pop_exp(d, w, e);
        total_cnt++;
        if (d !== e || FABINT !== 1'b1) $display("FAIL irq_pop got %h int=%b exp %h int=1", d, FABINT, e);
        else pass_cnt++;
        @(posedge FAB_CLK); #1;
        total_cnt++;
        if (FABINT !== 1'b0) $display("FAIL irq_fall got %b exp 0", FABINT);
        else pass_cnt++;
    endtask

    task automatic test_sof();
        logic [31:0] d, e;
        int w;
        ahb_write(4'h8, 32'h5);
        q.delete(); ph_m = 0; en_m = 1;
        ahb_read(4'h8, d, w);
        total_cnt++;
        if (d !== 32'h1) $display("FAIL flush_selfclear got %h exp 00000001", d);
        else pass_cnt++;
        pix(8'hAA, 1'b0);
        pix(8'hBB, 1'b0);
        pix(8'h11, 1'b1);
        pix(8'h22, 1'b0);
        pix(8'h33, 1'b0);
        pix(8'h44, 1'b0);
        idle();
        ahb_read(4'h4, d, w);
        total_cnt++;
        if (d !== exp_status() || d[15:0] !== 16'd1) $display("FAIL sof_level got %h exp %h", d, exp_status());
        else pass_cnt++;
        pop_exp(d, w, e);
        total_cnt++;
        if (d !== e || d !== 32'h4433_2211) $display("FAIL sof_word got %h exp %h", d, e);
        else pass_cnt++;
    endtask

    task automatic test_empty_and_simul();
        logic [31:0] d, e, rd;
        int w;
        pop_exp(d, w, e);
        total_cnt++;
        if (d !== 32'h0 || w !== 1) $display("FAIL empty_read got %h w=%0d exp 00000000 w=1", d, w);
        else pass_cnt++;
        ahb_read(4'h4, d, w);
        total_cnt++;
        if (d !== exp_status() || d[15:0] !== 16'd0) $display("FAIL empty_level got %h exp %h", d, exp_status());
        else pass_cnt++;
        for (int i = 0; i < 15; i++) pix(8'h60 + 8'(i), 1'b0);
        idle();
        fork
            pop_exp(rd, w, e);
            begin
                pix(8'h6F, 1'b0);
                idle();
            end
        join
        total_cnt++;
        if (rd !== e || w !== 1) $display("FAIL simul_pop got %h w=%0d exp %h w=1", rd, w, e);
        else pass_cnt++;
        ahb_read(4'h4, d, w);
        total_cnt++;
        if (d !== exp_status() || d[15:0] !== 16'd3) $display("FAIL simul_level got %h exp %h", d, exp_status());
        else pass_cnt++;
        for (int k = 0; k < 3; k++) begin
            pop_exp(d, w, e);
            total_cnt++;
            if (d !== e) $display("FAIL back_to_back%0d got %h exp %h", k, d, e);
            else pass_cnt++;
        end
    endtask

    task automatic test_reset_wait();
        pix(8'h01, 1'b0);
        pix(8'h02, 1'b0);
        pix(8'h03, 1'b0);
        pix(8'h04, 1'b0);
        idle();
        @(posedge FAB_CLK); #1;
        HSEL = 1; HTRANS = 2'b10; HWRITE = 0; HADDR = 4'h0;
        @(posedge FAB_CLK); #1;
        HSEL = 0; HTRANS = 2'b00;
        total_cnt++;
        if (HREADYOUT !== 1'b0) $display("FAIL wait_state got %b exp 0", HREADYOUT);
        else pass_cnt++;
        FAB_RESET = 1;
        @(posedge FAB_CLK); #1;
        total_cnt++;
        if (HREADYOUT !== 1'b1 || HRDATA !== 32'h0) $display("FAIL reset_in_wait got rdy=%b rdata=%h exp 1 00000000", HREADYOUT, HRDATA);
        else pass_cnt++;
        FAB_RESET = 0;
    endtask

    initial begin
        test_reset();
        test_pack();
        test_full_overflow();
        test_irq();
        test_sof();
        test_empty_and_simul();
        test_reset_wait();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
